// File: rtl/mem_console_client_if.sv
// Memory network request/response channels for the console client.
// The client modport is the requester side; the server modport is the memory side.

interface MemNetReq #(
  parameter int p_opaq_bits = 8
);
  typedef struct packed {
    logic                   op;      // 0 = read, 1 = write
    logic [p_opaq_bits-1:0] opaque;
    logic [1:0]             origin;
    logic [31:0]            addr;
    logic [3:0]             len;
    logic [31:0]            data;
  } msg_t;

  logic val;
  logic rdy;
  msg_t msg;

  modport client (output val, output msg, input rdy);
  modport server (input val, input msg, output rdy);
endinterface

interface MemNetResp #(
  parameter int p_opaq_bits = 8
);
  typedef struct packed {
    logic                   op;
    logic [p_opaq_bits-1:0] opaque;
    logic [1:0]             origin;
    logic [31:0]            addr;
    logic [3:0]             len;
    logic [31:0]            data;
  } msg_t;

  logic val;
  logic rdy;
  msg_t msg;

  modport client (input val, input msg, output rdy);
  modport server (output val, output msg, input rdy);
endinterface

// File: rtl/mem_console_client.sv
// Console echo client: reads one character from the STDIN address, writes it
// to the STDOUT address, and follows a carriage return with a line feed.
//
// state    | meaning
// ---------+--------------------------------------------
// IDLE     | waiting for en
// RD_REQ   | issuing the STDIN read
// RD_WAIT  | waiting for the read response (character)
// WR_REQ   | issuing the STDOUT write of the character
// WR_WAIT  | waiting for the write acknowledge
// LF_REQ   | issuing the STDOUT write of a line feed
// LF_WAIT  | waiting for the line-feed acknowledge

module mem_console_client #(
  parameter int         p_opaq_bits = 8,
  parameter logic [1:0] p_origin    = 2'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  MemNetReq.client          req,
  MemNetResp.client         resp,
  output logic              busy,
  output logic [15:0]       echo_count,
  output logic [7:0]        last_char,
  output logic              tag_err
);

  localparam logic [31:0] ADDR_STDOUT = 32'hF000_0000;
  localparam logic [31:0] ADDR_STDIN  = 32'hF000_0004;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_LF_REQ, S_LF_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [p_opaq_bits-1:0] opaq_q, opaq_d;
  logic [p_opaq_bits-1:0] sent_q, sent_d;
  logic [15:0]            echo_q, echo_d;
  logic [7:0]             char_q, char_d;
  logic                   tag_q, tag_d;
  logic                   req_val_q, req_val_d;
  logic                   resp_rdy_q, resp_rdy_d;
  logic                   op_q, op_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic                   req_hs;
  logic                   resp_hs;

  // Handshake/response bookkeeping, FSM transitions and next request outputs.
  always_comb begin
    state_d    = state_q;
    opaq_d     = opaq_q;
    sent_d     = sent_q;
    echo_d     = echo_q;
    char_d     = char_q;
    tag_d      = tag_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;

    req_hs  = req_val_q & req.rdy;
    resp_hs = resp_rdy_q & resp.val;

    if (req_hs) begin
      opaq_d = opaq_q + 1'b1;
      sent_d = opaq_q;
    end
    if (resp_hs && (resp.msg.opaque != sent_q)) begin
      tag_d = 1'b1;
    end

    case (state_q)
      S_IDLE:    if (en) state_d = S_RD_REQ;
      S_RD_REQ:  if (req_hs) state_d = S_RD_WAIT;
      S_RD_WAIT: if (resp_hs) begin
                   char_d  = resp.msg.data[7:0];
                   state_d = S_WR_REQ;
                 end
      S_WR_REQ:  if (req_hs) state_d = S_WR_WAIT;
      S_WR_WAIT: if (resp_hs) begin
                   if (char_q == 8'h0D) begin
                     state_d = S_LF_REQ;
                   end else begin
                     state_d = S_IDLE;
                     echo_d  = echo_q + 16'd1;
                   end
                 end
      S_LF_REQ:  if (req_hs) state_d = S_LF_WAIT;
      S_LF_WAIT: if (resp_hs) begin
                   state_d = S_IDLE;
                   echo_d  = echo_q + 16'd1;
                 end
      default:   state_d = S_IDLE;
    endcase

    // Outputs are registered off the next state so they line up with it.
    req_val_d  = (state_d == S_RD_REQ) || (state_d == S_WR_REQ) || (state_d == S_LF_REQ);
    resp_rdy_d = (state_d == S_RD_WAIT) || (state_d == S_WR_WAIT) || (state_d == S_LF_WAIT);

    case (state_d)
      S_RD_REQ: begin op_d = 1'b0; addr_d = ADDR_STDIN;  data_d = 32'h0; end
      S_WR_REQ: begin op_d = 1'b1; addr_d = ADDR_STDOUT; data_d = {24'b0, char_d}; end
      S_LF_REQ: begin op_d = 1'b1; addr_d = ADDR_STDOUT; data_d = 32'h0000_000A; end
      default:  ;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      opaq_q     <= '0;
      sent_q     <= '0;
      echo_q     <= '0;
      char_q     <= '0;
      tag_q      <= 1'b0;
      req_val_q  <= 1'b0;
      resp_rdy_q <= 1'b0;
      op_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      opaq_q     <= opaq_d;
      sent_q     <= sent_d;
      echo_q     <= echo_d;
      char_q     <= char_d;
      tag_q      <= tag_d;
      req_val_q  <= req_val_d;
      resp_rdy_q <= resp_rdy_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign req.val    = req_val_q;
  assign req.msg    = {op_q, opaq_q, p_origin, addr_q, 4'd4, data_q};
  assign resp.rdy   = resp_rdy_q;
  assign busy       = (state_q != S_IDLE);
  assign echo_count = echo_q;
  assign last_char  = char_q;
  assign tag_err    = tag_q;

endmodule

// File: tb/tb_mem_console_client.sv
// Directed bench for the console echo client; the bench plays the memory server.

module tb_mem_console_client;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  MemNetReq  #(.p_opaq_bits(8)) req ();
  MemNetResp #(.p_opaq_bits(8)) resp ();

  logic        busy;
  logic [15:0] echo_count;
  logic [7:0]  last_char;
  logic        tag_err;

  mem_console_client #(.p_opaq_bits(8), .p_origin(2'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .resp       (resp),
    .busy       (busy),
    .echo_count (echo_count),
    .last_char  (last_char),
    .tag_err    (tag_err)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  opq_m = 8'h00;
  logic        bulk = 1'b0;
  logic [7:0]  srv_opaq = 8'h00;
  logic [7:0]  tb_ropaq = 8'h00;
  logic [31:0] tb_rdata = 32'h0;

  // Server echoes the opaque of the request it last accepted (free-running mode).
  always @(posedge clk) if (req.val && req.rdy) srv_opaq <= req.msg.opaque;

  assign resp.msg = {1'b0, (bulk ? srv_opaq : tb_ropaq), 2'b00, 32'h0, 4'd4, tb_rdata};

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(string nm, logic op, logic [31:0] addr, logic [31:0] data, int stall);
    int n = 0;
    while (req.val !== 1'b1 && n < 50) begin tick(); n++; end
    check({nm, "_req_val"}, {31'b0, req.val}, 32'd1);
    check({nm, "_op"},     {31'b0, req.msg.op}, {31'b0, op});
    check({nm, "_addr"},   req.msg.addr, addr);
    check({nm, "_data"},   req.msg.data, data);
    check({nm, "_len"},    {28'b0, req.msg.len}, 32'd4);
    check({nm, "_opaque"}, {24'b0, req.msg.opaque}, {24'b0, opq_m});
    for (int i = 0; i < stall; i++) begin
      tick();
      check({nm, "_stall_val"},  {31'b0, req.val}, 32'd1);
      check({nm, "_stall_addr"}, req.msg.addr, addr);
      check({nm, "_stall_data"}, req.msg.data, data);
      check({nm, "_stall_opq"},  {24'b0, req.msg.opaque}, {24'b0, opq_m});
    end
    req.rdy = 1'b1;
    tick();
    req.rdy = 1'b0;
    opq_m++;
    check({nm, "_single_outstanding"}, {31'b0, req.val}, 32'd0);
  endtask

  task automatic respond(string nm, logic [31:0] rdata, logic [7:0] ropaq);
    int n = 0;
    while (resp.rdy !== 1'b1 && n < 50) begin tick(); n++; end
    check({nm, "_resp_rdy"}, {31'b0, resp.rdy}, 32'd1);
    tb_rdata = rdata;
    tb_ropaq = ropaq;
    resp.val = 1'b1;
    tick();
    resp.val = 1'b0;
  endtask

  task automatic start();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  initial begin
    req.rdy  = 1'b0;
    resp.val = 1'b0;

    // reset state
    rst = 1'b0;
    tick(); tick(); tick();
    check("rst_busy",   {31'b0, busy}, 32'd0);
    check("rst_reqval", {31'b0, req.val}, 32'd0);
    check("rst_resprdy",{31'b0, resp.rdy}, 32'd0);
    check("rst_echo",   {16'b0, echo_count}, 32'd0);
    check("rst_char",   {24'b0, last_char}, 32'd0);
    check("rst_tag",    {31'b0, tag_err}, 32'd0);
    rst = 1'b1;
    tick();
    check("idle_no_en", {31'b0, busy}, 32'd0);

    // plain character 0x41 with a 3-cycle stall on the read request
    start();
    check("a_busy", {31'b0, busy}, 32'd1);
    issue("a_rd", 1'b0, 32'hF000_0004, 32'h0, 3);
    respond("a_rd", 32'h0000_0041, opq_m - 8'd1);
    issue("a_wr", 1'b1, 32'hF000_0000, 32'h41, 0);
    respond("a_wr", 32'h0, opq_m - 8'd1);
    check("a_busy_fall", {31'b0, busy}, 32'd0);
    check("a_echo",      {16'b0, echo_count}, 32'd1);
    check("a_char",      {24'b0, last_char}, 32'h41);
    check("a_tag",       {31'b0, tag_err}, 32'd0);

    // carriage return gets a following line feed
    start();
    issue("b_rd", 1'b0, 32'hF000_0004, 32'h0, 0);
    respond("b_rd", 32'h0000_000D, opq_m - 8'd1);
    issue("b_wr", 1'b1, 32'hF000_0000, 32'h0D, 0);
    respond("b_wr", 32'h0, opq_m - 8'd1);
    check("b_busy_mid", {31'b0, busy}, 32'd1);
    check("b_echo_mid", {16'b0, echo_count}, 32'd1);
    issue("b_lf", 1'b1, 32'hF000_0000, 32'h0A, 0);
    respond("b_lf", 32'h0, opq_m - 8'd1);
    check("b_echo",  {16'b0, echo_count}, 32'd2);
    check("b_busy",  {31'b0, busy}, 32'd0);
    check("b_char",  {24'b0, last_char}, 32'h0D);
    check("b_tag",   {31'b0, tag_err}, 32'd0);

    // reset while waiting for the write acknowledge
    start();
    issue("d_rd", 1'b0, 32'hF000_0004, 32'h0, 0);
    respond("d_rd", 32'h0000_0055, opq_m - 8'd1);
    issue("d_wr", 1'b1, 32'hF000_0000, 32'h55, 0);
    check("d_in_wait", {31'b0, resp.rdy}, 32'd1);
    rst = 1'b0;
    tick();
    check("d_rst_busy",    {31'b0, busy}, 32'd0);
    check("d_rst_reqval",  {31'b0, req.val}, 32'd0);
    check("d_rst_resprdy", {31'b0, resp.rdy}, 32'd0);
    check("d_rst_echo",    {16'b0, echo_count}, 32'd0);
    check("d_rst_char",    {24'b0, last_char}, 32'd0);
    check("d_rst_opq",     {24'b0, req.msg.opaque}, 32'd0);
    rst = 1'b1;
    opq_m = 8'h00;
    tb_rdata = 32'h77;
    tb_ropaq = 8'h06;
    resp.val = 1'b1;
    tick(); tick();
    resp.val = 1'b0;
    check("d_stray_busy", {31'b0, busy}, 32'd0);
    check("d_stray_char", {24'b0, last_char}, 32'd0);
    check("d_stray_echo", {16'b0, echo_count}, 32'd0);
    check("d_stray_tag",  {31'b0, tag_err}, 32'd0);

    // opaque mismatch: 0x05 returned where 0x00 was issued
    start();
    issue("e_rd", 1'b0, 32'hF000_0004, 32'h0, 0);
    respond("e_rd", 32'h0000_0033, 8'h05);
    check("e_tag_set",  {31'b0, tag_err}, 32'd1);
    check("e_busy_mid", {31'b0, busy}, 32'd1);
    issue("e_wr", 1'b1, 32'hF000_0000, 32'h33, 0);
    respond("e_wr", 32'h0, opq_m - 8'd1);
    check("e_tag_sticky", {31'b0, tag_err}, 32'd1);
    check("e_echo",       {16'b0, echo_count}, 32'd1);
    check("e_busy",       {31'b0, busy}, 32'd0);

    // free-running server: 5-cycle echo latency, then 256 back-to-back echoes
    rst = 1'b0;
    tick();
    rst = 1'b1;
    opq_m = 8'h00;
    check("f_tag_clear", {31'b0, tag_err}, 32'd0);
    bulk = 1'b1;
    tb_rdata = 32'h41;
    req.rdy = 1'b1;
    resp.val = 1'b1;
    en = 1'b1;
    tick(); tick(); tick(); tick();
    check("f_lat4_echo", {16'b0, echo_count}, 32'd0);
    check("f_lat4_busy", {31'b0, busy}, 32'd1);
    tick();
    check("f_lat5_echo", {16'b0, echo_count}, 32'd1);
    check("f_lat5_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 255 * 5; i++) tick();
    en = 1'b0;
    check("f_echo_256", {16'b0, echo_count}, 32'h100);
    check("f_busy_end", {31'b0, busy}, 32'd0);
    check("f_opq_wrap", {24'b0, req.msg.opaque}, 32'd0);
    check("f_no_tag",   {31'b0, tag_err}, 32'd0);
    check("f_char",     {24'b0, last_char}, 32'h41);
    tick();
    check("f_en_low_idle", {31'b0, busy}, 32'd0);
    bulk = 1'b0;
    req.rdy = 1'b0;
    resp.val = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
